fpu_issue: RTL and testbench



---
 rtl/fpu_issue.sv | 165 ++++++++++++++++
 tb/tb_fpu_issue.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue.sv
// fpu_issue: queues FPU divide/sqrt requests and runs the operand and result
// handshakes for one operation at a time, with a watchdog on the result wait.
module fpu_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        gclk_i,
  input  logic        grst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [63:0] req_a_i,
  input  logic [63:0] req_b_i,
  input  logic [3:0]  req_tag_i,
  output logic [1:0]  fpu_process_o,
  output logic [31:0] fpu_as_o,
  output logic [31:0] fpu_bs_o,
  output logic [63:0] fpu_ad_o,
  output logic [63:0] fpu_bd_o,
  output logic        fpu_a_stb_o,
  input  logic        fpu_a_ack_i,
  output logic        fpu_b_stb_o,
  input  logic        fpu_b_ack_i,
  input  logic [31:0] fpu_zs_i,
  input  logic [63:0] fpu_zd_i,
  input  logic        fpu_z_stb_i,
  output logic        fpu_z_ack_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [63:0] res_data_o,
  output logic [1:0]  res_op_o,
  output logic [3:0]  res_tag_o,
  output logic        res_timeout_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
  } req_t;

  typedef enum logic [2:0] {IDLE, SETUP, SEND_A, SEND_B, WAIT_Z, ACK_Z, OUT} state_e;

  state_e        state_q, state_d;
  req_t          mem_q [DEPTH];
  req_t          req_in, head;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          rdy_en_q;
  logic          push, pop, full, empty;

  logic [1:0]    proc_q;
  logic [63:0]   a_q, b_q, data_q;
  logic [3:0]    tag_q;
  logic          to_q;
  logic [CW-1:0] wd_q;
  logic          wd_last;

  assign req_in = '{op: req_op_i, a: req_a_i, b: req_b_i, tag: req_tag_i};
  assign head   = mem_q[rd_q];
  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  // rdy_en_q keeps req_ready low while reset is held.
  assign req_ready_o = rdy_en_q && !full;
  assign push   = req_valid_i && req_ready_o;
  assign pop    = (state_q == IDLE) && !empty;
  assign wd_last = (wd_q == CW'(TIMEOUT - 1));

  always_ff @(posedge gclk_i) begin
    if (!grst_n_i) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge gclk_i) begin
    if (push) mem_q[wr_q] <= req_in;
  end

  always_ff @(posedge gclk_i) begin
    if (!grst_n_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = SETUP;
      SETUP:   state_d = SEND_A;
      SEND_A:  if (fpu_a_ack_i) state_d = proc_q[0] ? WAIT_Z : SEND_B;
      SEND_B:  if (fpu_b_ack_i) state_d = WAIT_Z;
      // A result strobe on the final count beats the watchdog.
      WAIT_Z:  if (fpu_z_stb_i) state_d = ACK_Z;
               else if (wd_last) state_d = OUT;
      ACK_Z:   if (!fpu_z_stb_i) state_d = OUT;
      OUT:     if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fpu_a_stb_o = 1'b0;
    fpu_b_stb_o = 1'b0;
    fpu_z_ack_o = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      SEND_A:  fpu_a_stb_o = 1'b1;
      SEND_B:  fpu_b_stb_o = 1'b1;
      ACK_Z:   fpu_z_ack_o = 1'b1;
      OUT:     res_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Operands load on the pop edge so they are already driven during SETUP.
  always_ff @(posedge gclk_i) begin
    if (!grst_n_i) begin
      proc_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      data_q <= '0;
      to_q   <= 1'b0;
      wd_q   <= '0;
    end else begin
      wd_q <= (state_q == WAIT_Z) ? wd_q + CW'(1) : '0;
      if (pop) begin
        proc_q <= head.op;
        a_q    <= head.a;
        b_q    <= head.b;
        tag_q  <= head.tag;
        to_q   <= 1'b0;
      end
      if (state_q == WAIT_Z) begin
        if (fpu_z_stb_i) begin
          data_q <= proc_q[1] ? fpu_zd_i : {32'h0, fpu_zs_i};
        end else if (wd_last) begin
          data_q <= '0;
          to_q   <= 1'b1;
        end
      end
    end
  end

  assign fpu_process_o = proc_q;
  assign fpu_as_o      = a_q[31:0];
  assign fpu_ad_o      = a_q;
  assign fpu_bs_o      = b_q[31:0];
  assign fpu_bd_o      = b_q;
  assign res_data_o    = data_q;
  assign res_op_o      = proc_q;
  assign res_tag_o     = tag_q;
  assign res_timeout_o = to_q;

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: table vectors, directed corner sequences and random traffic
// against a behavioural FPU model and an in-order result scoreboard.
module tb_fpu_issue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        gclk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [3:0]  req_tag = '0;
  logic [1:0]  fpu_process;
  logic [31:0] fpu_as, fpu_bs;
  logic [63:0] fpu_ad, fpu_bd;
  logic        fpu_a_stb, fpu_b_stb, fpu_z_ack;
  logic        a_ack = 1'b0, b_ack = 1'b0, z_stb = 1'b0;
  logic [31:0] zs = '0;
  logic [63:0] zd = '0;
  logic        res_valid, res_timeout;
  logic        res_ready = 1'b1;
  logic [63:0] res_data;
  logic [1:0]  res_op;
  logic [3:0]  res_tag;

  fpu_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .gclk_i(gclk), .grst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .fpu_process_o(fpu_process), .fpu_as_o(fpu_as), .fpu_bs_o(fpu_bs),
    .fpu_ad_o(fpu_ad), .fpu_bd_o(fpu_bd),
    .fpu_a_stb_o(fpu_a_stb), .fpu_a_ack_i(a_ack),
    .fpu_b_stb_o(fpu_b_stb), .fpu_b_ack_i(b_ack),
    .fpu_zs_i(zs), .fpu_zd_i(zd), .fpu_z_stb_i(z_stb), .fpu_z_ack_o(fpu_z_ack),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_op_o(res_op), .res_tag_o(res_tag), .res_timeout_o(res_timeout)
  );

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    logic [63:0] z;
    int          a_dly;
    int          b_dly;
    int          lat;
    bit          hang;
  } fop_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic        to;
  } res_t;

  typedef struct {
    fop_t        f;
    logic [63:0] exp_data;
    logic        exp_to;
  } vec_t;

  fop_t fpu_q[$];
  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_mode = 0;

  task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Reference rule: single results are zero-extended, aborted results read zero.
  function automatic logic [63:0] exp_of(input fop_t f);
    if (f.hang) return 64'h0;
    return f.op[1] ? f.z : {32'h0, f.z[31:0]};
  endfunction

  function automatic fop_t mkf(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [3:0] tag, input logic [63:0] z,
                               input int ad, input int bd, input int lat, input bit hang);
    fop_t f;
    f.op = op; f.a = a; f.b = b; f.tag = tag; f.z = z;
    f.a_dly = ad; f.b_dly = bd; f.lat = lat; f.hang = hang;
    return f;
  endfunction

  // Behavioural FPU: acks operands after a delay, returns z after a latency.
  fop_t cur;
  bit   a_seen = 0, b_seen = 0, wz = 0;
  int   adly = 0, bdly = 0, wcnt = 0;
  always @(negedge gclk) begin
    if (!rst_n) begin
      a_ack = 1'b0; b_ack = 1'b0; z_stb = 1'b0;
      a_seen = 0; b_seen = 0; wz = 0;
    end else begin
      if (z_stb && fpu_z_ack) z_stb = 1'b0;
      if (a_ack) begin
        a_ack = 1'b0; a_seen = 0;
        chk1("a_stb_drop_after_ack", fpu_a_stb, 1'b0);
        chk1("b_stb_follows_a", fpu_b_stb, !cur.op[0]);
        if (cur.op[0]) begin wz = 1; wcnt = cur.lat; end
      end
      if (b_ack) begin
        b_ack = 1'b0; b_seen = 0;
        chk1("b_stb_drop_after_ack", fpu_b_stb, 1'b0);
        wz = 1; wcnt = cur.lat;
      end
      if (fpu_a_stb && !a_ack) begin
        if (!a_seen) begin
          a_seen = 1; wz = 0; z_stb = 1'b0;
          if (fpu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fpu_issue_unexpected actual=a_stb required=no_op");
          end else begin
            cur = fpu_q.pop_front();
          end
          chkw("fpu_process", 128'(fpu_process), 128'(cur.op));
          chkw("fpu_as", 128'(fpu_as), 128'(cur.a[31:0]));
          chkw("fpu_ad", 128'(fpu_ad), 128'(cur.a));
          chkw("fpu_bs", 128'(fpu_bs), 128'(cur.b[31:0]));
          chkw("fpu_bd", 128'(fpu_bd), 128'(cur.b));
          adly = cur.a_dly;
        end
        if (adly == 0) a_ack = 1'b1; else adly--;
      end
      if (fpu_b_stb && !b_ack) begin
        if (!b_seen) begin
          b_seen = 1; bdly = cur.b_dly;
          chk1("b_stb_only_for_div", cur.op[0], 1'b0);
        end
        if (bdly == 0) b_ack = 1'b1; else bdly--;
      end
      if (wz && !cur.hang) begin
        if (wcnt == 0) begin
          z_stb = 1'b1; zs = cur.z[31:0]; zd = cur.z; wz = 0;
        end else wcnt--;
      end
    end
  end

  // Result scoreboard, backpressure driver and hold/ordering checks.
  bit          pv = 0;
  logic [70:0] pres;
  res_t        er;
  always @(negedge gclk) begin
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
    if (rst_n) begin
      if (pv) begin
        chk1("res_valid_held", res_valid, 1'b1);
        chkw("res_fields_held", 128'({res_timeout, res_tag, res_op, res_data}), 128'(pres));
      end
      if (res_valid) chk1("no_issue_during_out", fpu_a_stb, 1'b0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=tag%0h required=none", res_tag);
        end else begin
          er = exp_q.pop_front();
          chkw("res_data", 128'(res_data), 128'(er.data));
          chkw("res_tag", 128'(res_tag), 128'(er.tag));
          chkw("res_op", 128'(res_op), 128'(er.op));
          chk1("res_timeout", res_timeout, er.to);
        end
      end
      pv   = res_valid && !res_ready;
      pres = {res_timeout, res_tag, res_op, res_data};
    end else begin
      pv = 0;
    end
  end

  task automatic send(input fop_t f, input logic [63:0] ed, input logic eto, output int waited);
    res_t r;
    req_valid = 1'b1; req_op = f.op; req_a = f.a; req_b = f.b; req_tag = f.tag;
    waited = 0;
    while (!req_ready && waited < 300) begin
      @(negedge gclk);
      waited++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout actual=ready0 required=ready1");
      req_valid = 1'b0;
      return;
    end
    fpu_q.push_back(f);
    r.data = ed; r.op = f.op; r.tag = f.tag; r.to = eto;
    exp_q.push_back(r);
    @(negedge gclk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge gclk);
      n++;
    end
    chkw(nm, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk1({nm, "_req_ready"}, req_ready, 1'b0);
    chkw({nm, "_ctl"}, 128'({fpu_a_stb, fpu_b_stb, fpu_z_ack, res_valid, res_timeout}), 128'(0));
    chkw({nm, "_ops"}, 128'({fpu_process, fpu_as, fpu_bs}), 128'(0));
    chkw({nm, "_ad"}, 128'(fpu_ad), 128'(0));
    chkw({nm, "_bd"}, 128'(fpu_bd), 128'(0));
    chkw({nm, "_res"}, 128'({res_data, res_op, res_tag}), 128'(0));
  endtask

  vec_t vt[8];
  int   w, e;
  bit   seen_a;
  fop_t f;

  initial begin
    vt[0] = '{mkf(2'b00, 64'h0000_0000_4040_0000, 64'h0000_0000_3F80_0000, 4'd3,
                  64'hFFFF_FFFF_4040_0000, 1, 1, 2, 0), 64'h0000_0000_4040_0000, 1'b0};
    vt[1] = '{mkf(2'b11, 64'h4010_0000_0000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 4'd5,
                  64'h4000_0000_0000_0000, 0, 0, 3, 0), 64'h4000_0000_0000_0000, 1'b0};
    vt[2] = '{mkf(2'b01, 64'h1111_2222_4080_0000, 64'h0, 4'd6,
                  64'h5555_6666_4000_0000, 0, 0, 0, 0), 64'h0000_0000_4000_0000, 1'b0};
    vt[3] = '{mkf(2'b10, 64'h4024_0000_0000_0000, 64'h4000_0000_0000_0000, 4'd7,
                  64'h4014_0000_0000_0000, 2, 3, 1, 0), 64'h4014_0000_0000_0000, 1'b0};
    vt[4] = '{mkf(2'b00, 64'h0000_0000_3F80_0000, 64'h0, 4'd8,
                  64'h0000_0000_1234_5678, 0, 0, 0, 1), 64'h0, 1'b1};
    vt[5] = '{mkf(2'b10, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 4'd9,
                  64'h0123_4567_89AB_CDEF, 0, 0, TIMEOUT - 1, 0), 64'h0123_4567_89AB_CDEF, 1'b0};
    vt[6] = '{mkf(2'b01, 64'h0000_0000_4100_0000, 64'h0, 4'd10,
                  64'h0, 1, 0, 0, 1), 64'h0, 1'b1};
    vt[7] = '{mkf(2'b00, 64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000, 4'd11,
                  64'hCAFE_0000_3F80_0000, 3, 0, TIMEOUT - 2, 0), 64'h0000_0000_3F80_0000, 1'b0};

    repeat (2) @(negedge gclk);
    chk_reset_vals("reset");
    #2 rst_n = 1'b1;
    @(negedge gclk);
    chk1("ready_after_reset", req_ready, 1'b1);

    // Issue latency: accepted at edge N, SETUP after N+1, a_stb after N+2.
    send(vt[0].f, vt[0].exp_data, vt[0].exp_to, w);
    chk1("lat_idle_no_stb", fpu_a_stb, 1'b0);
    @(negedge gclk);
    chk1("lat_setup_no_stb", fpu_a_stb, 1'b0);
    chkw("lat_setup_operand", 128'({fpu_process, fpu_as, fpu_bs}),
         128'({vt[0].f.op, vt[0].f.a[31:0], vt[0].f.b[31:0]}));
    @(negedge gclk);
    chk1("lat_send_a_stb", fpu_a_stb, 1'b1);
    drain("drain_latency");

    for (int i = 0; i < 8; i++) begin
      send(vt[i].f, vt[i].exp_data, vt[i].exp_to, w);
      drain("drain_vector");
    end

    // FIFO full: a stalled op holds the FSM while tags 0..4 arrive back-to-back.
    send(mkf(2'b11, 64'h1, 64'h2, 4'd15, 64'h77, 40, 0, 0, 0), 64'h77, 1'b0, w);
    for (int t = 0; t < 4; t++) begin
      f = mkf(2'(t), {32'h0, 32'(t)}, 64'h5, 4'(t), {32'hAB, 32'(t + 100)}, 0, 0, 1, 0);
      send(f, exp_of(f), 1'b0, w);
    end
    chk1("full_ready_low", req_ready, 1'b0);
    f = mkf(2'b01, 64'h4, 64'h0, 4'd4, 64'h9999_0000_0000_0044, 0, 0, 0, 0);
    send(f, exp_of(f), 1'b0, w);
    chk1("fifth_held", w > 0, 1'b1);
    drain("drain_full");

    // Backpressure: result held ten cycles with a second request queued.
    rr_mode = 2;
    f = mkf(2'b10, 64'h10, 64'h20, 4'd1, 64'hFEED_FACE_0000_0001, 0, 0, 2, 0);
    send(f, exp_of(f), 1'b0, w);
    f = mkf(2'b00, 64'h30, 64'h40, 4'd2, 64'h0000_0000_0000_0002, 0, 0, 0, 0);
    send(f, exp_of(f), 1'b0, w);
    e = 0;
    while (!res_valid && e < 100) begin @(negedge gclk); e++; end
    chk1("bp_result_present", res_valid, 1'b1);
    repeat (10) @(negedge gclk);
    chk1("bp_still_valid", res_valid, 1'b1);
    chk1("bp_no_next_issue", fpu_a_stb, 1'b0);
    rr_mode = 0;
    drain("drain_backpressure");

    // Watchdog: result appears TIMEOUT edges after WAIT_Z entry.
    f = mkf(2'b11, 64'h4010_0000_0000_0000, 64'h0, 4'd12, 64'h0, 0, 0, 0, 1);
    send(f, exp_of(f), 1'b1, w);
    e = 0;
    while (!fpu_a_stb && e < 50) begin @(negedge gclk); e++; end
    while (fpu_a_stb && e < 100) begin @(negedge gclk); e++; end
    e = 0;
    while (!res_valid && e < 100) begin @(negedge gclk); e++; end
    chkw("timeout_latency", 128'(e), 128'(TIMEOUT));
    drain("drain_timeout");

    // Reset during SEND_B with a second request queued behind it.
    f = mkf(2'b00, 64'h11, 64'h22, 4'd13, 64'h33, 0, 60, 0, 0);
    send(f, exp_of(f), 1'b0, w);
    f = mkf(2'b10, 64'h44, 64'h55, 4'd14, 64'h66, 0, 0, 0, 0);
    send(f, exp_of(f), 1'b0, w);
    e = 0;
    while (!fpu_b_stb && e < 50) begin @(negedge gclk); e++; end
    chk1("reached_send_b", fpu_b_stb, 1'b1);
    #2 rst_n = 1'b0;
    @(negedge gclk);
    chk_reset_vals("midop_reset");
    #2 rst_n = 1'b1;
    fpu_q.delete();
    exp_q.delete();
    seen_a = 0;
    repeat (20) begin
      @(negedge gclk);
      seen_a |= fpu_a_stb;
    end
    chk1("fifo_empty_after_reset", seen_a, 1'b0);

    // Random traffic with random result backpressure.
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      f = mkf(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom_range(0, 15)), {$urandom, $urandom},
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 6)), $urandom_range(0, 7) == 0);
      send(f, exp_of(f), f.hang, w);
      repeat ($urandom_range(0, 2)) @(negedge gclk);
    end
    drain("drain_random");
    rr_mode = 0;
    repeat (5) @(negedge gclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
